adc_capture_pktctrl: RTL and testbench

- Capture-and-replay core of the ADC capture chip.
- On a start pulse it fills an on-chip buffer with 18-bit samples, then reads the buffer out as framed packets: word valid, per-word gap, inter-packet idle.
- The samples come from the external ADC input or, in self-test mode, from an internal counter.
- A replay pulse re-reads the buffer without recapturing. Config fields arrive as ports from the top register file; MDIO/pad logic is outside this block.

---
 rtl/adc_capture_pkg.sv | 19 +
 rtl/capture_sram.sv | 28 ++
 rtl/adc_capture_pktctrl.sv | 158 +++++++++++++++
 tb/tb_adc_capture_pktctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC capture/replay core: FSM encoding, default widths, packet length decode.
package adc_capture_pkg;

    localparam int DW_DEF = 18;
    localparam int AW_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Packet payload in words: 216, 432, 864 or 1728.
    function automatic logic [10:0] pkt_words(input logic [1:0] code);
        return 11'd216 << code;
    endfunction

endpackage

// File: rtl/capture_sram.sv
// Single-port sample buffer; read data registered one cycle after the address, en=0 freezes it.
module capture_sram
    import adc_capture_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4096,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdat;
            end
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/adc_capture_pktctrl.sv
// Fills the buffer from the ADC or a self-test counter, then replays it as gapped packets.
// adc_data follows rd_addr by one cycle; cfg_clk_en=0 freezes everything, no other backpressure.
module adc_capture_pktctrl
    import adc_capture_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int MEM_DEPTH = 4096,
    parameter int AW        = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_clk_en,
    input  logic          cfg_sw_rstn,
    input  logic          cfg_self_test_mode,
    input  logic [7:0]    cfg_pkt_gap,
    input  logic [1:0]    cfg_pkt_data_length,
    input  logic [7:0]    cfg_pkt_idle_length,
    input  logic          capture_start,
    input  logic          capture_again,
    input  logic [DW-1:0] adc_in_data,
    input  logic          adc_in_valid,
    output logic [DW-1:0] adc_data,
    output logic          adc_data_valid,
    output logic [AW-1:0] rd_addr,
    output logic [1:0]    curr_sta,
    output logic          fast_rd_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_addr;
    logic          mem_valid;
    logic          rd_vld_q;
    logic [DW-1:0] st_cnt;
    logic [7:0]    gap_q, idle_q, gap_cnt;
    logic [10:0]   pkt_len_q, word_cnt;
    logic          srst, wr_fire, rd_last, pkt_last, load_cfg, start_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat, ram_rdat;

    assign srst     = !rstn || !cfg_sw_rstn;
    assign wr_fire  = (state == WRITE) && (cfg_self_test_mode || adc_in_valid);
    assign rd_last  = (state == READ) && (rd_addr == LAST_ADDR);
    assign pkt_last = (word_cnt == pkt_len_q - 11'd1);
    assign ram_addr = (state == WRITE) ? wr_addr : rd_addr;
    assign ram_wdat = cfg_self_test_mode ? st_cnt : adc_in_data;

    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        load_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (capture_start) begin
                    state_nxt = WRITE;
                    start_wr  = 1'b1;
                end else if (capture_again && mem_valid) begin
                    state_nxt = READ;
                    load_cfg  = 1'b1;
                end
            end
            WRITE: begin
                if (wr_fire && (wr_addr == LAST_ADDR)) begin
                    state_nxt = READ;
                    load_cfg  = 1'b1;
                end
            end
            READ: begin
                // End of packet takes the idle spacing instead of the word gap.
                if (rd_last) begin
                    state_nxt = IDLE;
                end else if (pkt_last) begin
                    state_nxt = (idle_q != 8'd0) ? GAP : READ;
                end else begin
                    state_nxt = (gap_q != 8'd0) ? GAP : READ;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_nxt = READ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
        end else if (cfg_clk_en) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            mem_valid <= 1'b0;
            rd_vld_q  <= 1'b0;
            st_cnt    <= '0;
            gap_cnt   <= '0;
            word_cnt  <= '0;
            gap_q     <= '0;
            idle_q    <= '0;
            pkt_len_q <= 11'd216;
        end else if (cfg_clk_en) begin
            rd_vld_q <= (state == READ);
            if (start_wr) begin
                wr_addr   <= '0;
                st_cnt    <= '0;
                mem_valid <= 1'b0;
            end
            if (state == WRITE) begin
                st_cnt <= st_cnt + 1'b1;
                if (wr_fire) begin
                    wr_addr <= wr_addr + 1'b1;
                end
                if (wr_fire && (wr_addr == LAST_ADDR)) begin
                    mem_valid <= 1'b1;
                    rd_addr   <= '0;
                end
            end
            if (load_cfg) begin
                gap_q     <= cfg_pkt_gap;
                idle_q    <= cfg_pkt_idle_length;
                pkt_len_q <= pkt_words(cfg_pkt_data_length);
                word_cnt  <= '0;
            end
            if (state == READ) begin
                rd_addr  <= rd_last ? '0 : rd_addr + 1'b1;
                word_cnt <= pkt_last ? '0 : word_cnt + 1'b1;
                gap_cnt  <= pkt_last ? idle_q : gap_q;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    capture_sram #(
        .DW    (DW),
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk  (clk),
        .en   (cfg_clk_en && !srst),
        .we   (wr_fire),
        .addr (ram_addr),
        .wdat (ram_wdat),
        .rdat (ram_rdat)
    );

    assign adc_data       = rd_vld_q ? ram_rdat : '0;
    assign adc_data_valid = rd_vld_q;
    assign curr_sta       = state;
    assign fast_rd_done   = rd_last;

endmodule

// File: tb/tb_adc_capture_pktctrl.sv
// Scoreboard bench for adc_capture_pktctrl with a 1024-word buffer.
`timescale 1ns/1ps
module tb_adc_capture_pktctrl;

    localparam int DW    = 18;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rstn, cfg_clk_en, cfg_sw_rstn, cfg_self_test_mode;
    logic [7:0]    cfg_pkt_gap, cfg_pkt_idle_length;
    logic [1:0]    cfg_pkt_data_length;
    logic          capture_start, capture_again, adc_in_valid;
    logic [DW-1:0] adc_in_data, adc_data;
    logic          adc_data_valid, fast_rd_done;
    logic [AW-1:0] rd_addr;
    logic [1:0]    curr_sta;

    adc_capture_pktctrl #(.DW(DW), .MEM_DEPTH(DEPTH), .AW(AW)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cfg_clk_en          (cfg_clk_en),
        .cfg_sw_rstn         (cfg_sw_rstn),
        .cfg_self_test_mode  (cfg_self_test_mode),
        .cfg_pkt_gap         (cfg_pkt_gap),
        .cfg_pkt_data_length (cfg_pkt_data_length),
        .cfg_pkt_idle_length (cfg_pkt_idle_length),
        .capture_start       (capture_start),
        .capture_again       (capture_again),
        .adc_in_data         (adc_in_data),
        .adc_in_valid        (adc_in_valid),
        .adc_data            (adc_data),
        .adc_data_valid      (adc_data_valid),
        .rd_addr             (rd_addr),
        .curr_sta            (curr_sta),
        .fast_rd_done        (fast_rd_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_dat[$];
    int            mon_ec[$];
    int            ecyc = 0, done_cnt = 0, done_ec = 0, zero_viol = 0;
    logic [1:0]    done_sta = '0;
    logic [AW-1:0] done_addr = '0;
    logic          en_last = 1'b0;
    int            base_w = 0, base_d = 0;

    // ecyc counts only enabled edges, so frozen cycles vanish from the timing model.
    always @(posedge clk) begin
        en_last <= cfg_clk_en;
        if (cfg_clk_en) ecyc <= ecyc + 1;
    end

    always @(negedge clk) begin
        if (en_last) begin
            if (adc_data_valid) begin
                mon_dat.push_back(adc_data);
                mon_ec.push_back(ecyc);
            end else if (adc_data !== '0) begin
                zero_viol <= zero_viol + 1;
            end
            if (fast_rd_done) begin
                done_cnt  <= done_cnt + 1;
                done_sta  <= curr_sta;
                done_addr <= rd_addr;
                done_ec   <= ecyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic kick(input logic s, input logic a, output int start_ec);
        base_w        = mon_dat.size();
        base_d        = done_cnt;
        start_ec      = ecyc;
        capture_start = s;
        capture_again = a;
        step(1);
        capture_start = 1'b0;
        capture_again = 1'b0;
    endtask

    task automatic push_ramp();
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(DW'(k));
    endtask

    task automatic set_cfg(input logic st, input logic [1:0] len, input logic [7:0] gap, input logic [7:0] idle);
        cfg_self_test_mode  = st;
        cfg_pkt_data_length = len;
        cfg_pkt_gap         = gap;
        cfg_pkt_idle_length = idle;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            step(1);
            if (done_cnt > base_d) ok = 1'b1;
        end
        step(2);
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            step(1);
            if (mon_dat.size() - base_w >= n) ok = 1'b1;
        end
    endtask

    function automatic int data_errs();
        int e = 0;
        int n = mon_dat.size() - base_w;
        if (n != exp_q.size()) e++;
        for (int i = 0; i < n && exp_q.size() > 0; i++)
            if (mon_dat[base_w + i] !== exp_q.pop_front()) e++;
        return e;
    endfunction

    // Word i starts a new packet when i % L == 0; that spacing is idle+1, otherwise gap+1.
    function automatic int timing_errs(input int first_ec, input int l, input int gap, input int idle);
        int e = 0;
        if (mon_ec.size() <= base_w) return 1;
        if (mon_ec[base_w] != first_ec) e++;
        for (int i = 1; base_w + i < mon_ec.size(); i++)
            if (mon_ec[base_w + i] - mon_ec[base_w + i - 1] != ((i % l == 0) ? idle + 1 : gap + 1)) e++;
        return e;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        step(3);
        n_checks++;
        if ({adc_data, adc_data_valid, rd_addr, curr_sta, fast_rd_done} !== '0)
            $display("FAIL reset_outputs got data=%h vld=%b addr=%0d sta=%0d done=%b exp all 0",
                     adc_data, adc_data_valid, rd_addr, curr_sta, fast_rd_done);
        else n_pass++;
        rstn = 1'b1;
        step(2);
    endtask

    task automatic test_capture_read();
        int sec, e;
        bit ok;
        set_cfg(1'b1, 2'd1, 8'd4, 8'd1);
        push_ramp();
        kick(1'b1, 1'b0, sec);
        n_checks++;
        if (curr_sta !== 2'd2) $display("FAIL s1_write_state got %0d exp 2", curr_sta); else n_pass++;
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL s1_done_timeout got %0d exp 1", ok); else n_pass++;
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s1_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 1026, 432, 4, 1);
        n_checks++;
        if (e !== 0) $display("FAIL s1_timing_errs got %0d exp 0", e); else n_pass++;
        n_checks++;
        if (done_cnt - base_d !== 1) $display("FAIL s1_done_count got %0d exp 1", done_cnt - base_d); else n_pass++;
        n_checks++;
        if (done_sta !== 2'd1) $display("FAIL s1_done_sta got %0d exp 1", done_sta); else n_pass++;
        n_checks++;
        if (done_addr !== AW'(DEPTH - 1)) $display("FAIL s1_done_addr got %0d exp %0d", done_addr, DEPTH - 1); else n_pass++;
        n_checks++;
        if (mon_ec[mon_ec.size() - 1] !== done_ec + 1)
            $display("FAIL s1_last_word_ec got %0d exp %0d", mon_ec[mon_ec.size() - 1], done_ec + 1);
        else n_pass++;
        n_checks++;
        if ({curr_sta, rd_addr} !== '0) $display("FAIL s1_end_idle got sta=%0d addr=%0d exp 0 0", curr_sta, rd_addr); else n_pass++;
    endtask

    task automatic test_replay();
        int sec, e;
        bit ok;
        push_ramp();
        kick(1'b0, 1'b1, sec);
        n_checks++;
        if (curr_sta !== 2'd1) $display("FAIL s2_read_state got %0d exp 1", curr_sta); else n_pass++;
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL s2_done_timeout got %0d exp 1", ok); else n_pass++;
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s2_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 2, 432, 4, 1);
        n_checks++;
        if (e !== 0) $display("FAIL s2_timing_errs got %0d exp 0", e); else n_pass++;
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
        kick(1'b0, 1'b1, sec);
        step(60);
        n_checks++;
        if (mon_dat.size() - base_w !== 0) $display("FAIL s2_again_no_mem got %0d words exp 0", mon_dat.size() - base_w); else n_pass++;
        n_checks++;
        if (curr_sta !== 2'd0) $display("FAIL s2_again_state got %0d exp 0", curr_sta); else n_pass++;
    endtask

    task automatic test_contiguous();
        int sec, e;
        bit ok;
        set_cfg(1'b1, 2'd3, 8'd0, 8'd0);
        push_ramp();
        kick(1'b1, 1'b0, sec);
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL s3_done_timeout got %0d exp 1", ok); else n_pass++;
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s3_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 1026, 1728, 0, 0);
        n_checks++;
        if (e !== 0) $display("FAIL s3_timing_errs got %0d exp 0", e); else n_pass++;
    endtask

    task automatic test_external();
        int sec, e;
        bit ok;
        set_cfg(1'b0, 2'd1, 8'd4, 8'd1);
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(18'h3FFFF - DW'(k));
        kick(1'b1, 1'b0, sec);
        for (int k = 0; k < DEPTH; k++) begin
            adc_in_valid = 1'b1;
            adc_in_data  = 18'h3FFFF - DW'(k);
            step(1);
            adc_in_valid = 1'b0;
            adc_in_data  = 18'h15555;
            step(1);
        end
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL s4_done_timeout got %0d exp 1", ok); else n_pass++;
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s4_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 2049, 432, 4, 1);
        n_checks++;
        if (e !== 0) $display("FAIL s4_timing_errs got %0d exp 0", e); else n_pass++;
    endtask

    task automatic test_pulses_and_freeze();
        int sec, e, hold_n;
        logic [AW-1:0] hold_addr;
        bit ok;
        set_cfg(1'b1, 2'd1, 8'd4, 8'd1);
        push_ramp();
        kick(1'b1, 1'b0, sec);
        wait_words(500, ok);
        capture_start = 1'b1;
        step(1);
        capture_start = 1'b0;
        n_checks++;
        if (!(curr_sta == 2'd1 || curr_sta == 2'd3)) $display("FAIL s5_start_in_read got %0d exp 1 or 3", curr_sta); else n_pass++;
        hold_addr  = rd_addr;
        hold_n     = mon_dat.size();
        cfg_clk_en = 1'b0;
        step(10);
        n_checks++;
        if (rd_addr !== hold_addr) $display("FAIL s5_freeze_addr got %0d exp %0d", rd_addr, hold_addr); else n_pass++;
        n_checks++;
        if (mon_dat.size() !== hold_n) $display("FAIL s5_freeze_words got %0d exp %0d", mon_dat.size(), hold_n); else n_pass++;
        cfg_clk_en = 1'b1;
        wait_done(ok);
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s5_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 1026, 432, 4, 1);
        n_checks++;
        if (e !== 0) $display("FAIL s5_timing_errs got %0d exp 0", e); else n_pass++;
        kick(1'b1, 1'b1, sec);
        n_checks++;
        if (curr_sta !== 2'd2) $display("FAIL s5_both_pulses got %0d exp 2", curr_sta); else n_pass++;
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
    endtask

    task automatic test_sw_reset();
        int sec, e;
        bit ok;
        set_cfg(1'b1, 2'd1, 8'd4, 8'd1);
        kick(1'b1, 1'b0, sec);
        wait_words(100, ok);
        cfg_sw_rstn = 1'b0;
        step(1);
        n_checks++;
        if ({adc_data, adc_data_valid, rd_addr, curr_sta, fast_rd_done} !== '0)
            $display("FAIL s6_sw_reset got data=%h vld=%b addr=%0d sta=%0d done=%b exp all 0",
                     adc_data, adc_data_valid, rd_addr, curr_sta, fast_rd_done);
        else n_pass++;
        cfg_sw_rstn = 1'b1;
        step(1);
        kick(1'b0, 1'b1, sec);
        step(20);
        n_checks++;
        if (mon_dat.size() - base_w !== 0) $display("FAIL s6_again_ignored got %0d words exp 0", mon_dat.size() - base_w); else n_pass++;
        push_ramp();
        kick(1'b1, 1'b0, sec);
        wait_done(ok);
        e = data_errs();
        n_checks++;
        if (e !== 0) $display("FAIL s6_data_errs got %0d exp 0", e); else n_pass++;
        e = timing_errs(sec + 1026, 432, 4, 1);
        n_checks++;
        if (e !== 0) $display("FAIL s6_timing_errs got %0d exp 0", e); else n_pass++;
        n_checks++;
        if (zero_viol !== 0) $display("FAIL data_zero_when_invalid got %0d exp 0", zero_viol); else n_pass++;
    endtask

    initial begin
        rstn          = 1'b0;
        cfg_clk_en    = 1'b1;
        cfg_sw_rstn   = 1'b1;
        capture_start = 1'b0;
        capture_again = 1'b0;
        adc_in_valid  = 1'b0;
        adc_in_data   = '0;
        set_cfg(1'b1, 2'd1, 8'd4, 8'd1);
        test_reset();
        test_capture_read();
        test_replay();
        test_contiguous();
        test_external();
        test_pulses_and_freeze();
        test_sw_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
